// File: rtl/db_ext_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : db_ext_access_pkg
// Purpose  : Shared encodings for the deblocking external-memory access
//            block: default pixel/MB widths, per-mode beat counts, block
//            start indices, FSM state encoding and the beat-to-block map.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package db_ext_access_pkg;

  localparam int DEF_BIT_DEPTH    = 8;
  localparam int DEF_PIC_W_MB_LEN = 8;
  localparam int DEF_PIC_H_MB_LEN = 8;

  // Beats per command, indexed by mode {uv, full}
  localparam logic [4:0] BEATS_Y_BOT   = 5'd4;
  localparam logic [4:0] BEATS_UV_BOT  = 5'd4;
  localparam logic [4:0] BEATS_Y_FULL  = 5'd16;
  localparam logic [4:0] BEATS_UV_FULL = 5'd8;

  // First 4x4 block index of each run
  localparam logic [4:0] BLK_Y_BOT   = 5'd12;
  localparam logic [4:0] BLK_U_BOT   = 5'd18;
  localparam logic [4:0] BLK_V_BOT   = 5'd22;
  localparam logic [4:0] BLK_Y_FULL  = 5'd0;
  localparam logic [4:0] BLK_UV_FULL = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_FETCH = 3'd3,
    S_WR_REQ   = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  function automatic logic [4:0] beat_count(input logic [1:0] mode);
    case (mode)
      2'b00:   beat_count = BEATS_Y_BOT;
      2'b10:   beat_count = BEATS_UV_BOT;
      2'b01:   beat_count = BEATS_Y_FULL;
      default: beat_count = BEATS_UV_FULL;
    endcase
  endfunction

  // Chroma bottom line is two non-contiguous pairs: U 18,19 then V 22,23.
  function automatic logic [4:0] blk_index(input logic [1:0] mode,
                                           input logic [4:0] beat);
    case (mode)
      2'b00:   blk_index = BLK_Y_BOT + beat;
      2'b10:   blk_index = (beat[1] ? BLK_V_BOT : BLK_U_BOT) + {4'b0, beat[0]};
      2'b01:   blk_index = BLK_Y_FULL + beat;
      default: blk_index = BLK_UV_FULL + beat;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/db_ext_access_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : db_ext_addr_gen
// Purpose  : Macroblock offset (y*(total_x+1)+x) and 4x4-block to external
//            16-byte word address mapping for luma and chroma planes.
// Ports    : total_x_i/mb_x_i/mb_y_i -> mb_off_o (combinational offset)
//            mb_off_i/uv_i/blk_i      -> addr_o   (word address)
// Revision : 1.0 - initial release
// ============================================================================
module db_ext_addr_gen
  import db_ext_access_pkg::*;
#(
  parameter int          PIC_W_MB_LEN = DEF_PIC_W_MB_LEN,
  parameter int          PIC_H_MB_LEN = DEF_PIC_H_MB_LEN,
  parameter logic [31:0] Y_BASE       = 32'h0,
  parameter logic [31:0] UV_BASE      = 32'h0010_0000
) (
  input  logic [PIC_W_MB_LEN-1:0] total_x_i,
  input  logic [PIC_W_MB_LEN-1:0] mb_x_i,
  input  logic [PIC_H_MB_LEN-1:0] mb_y_i,
  output logic [31:0]             mb_off_o,
  input  logic [31:0]             mb_off_i,
  input  logic                    uv_i,
  input  logic [4:0]              blk_i,
  output logic [31:0]             addr_o
);

  logic [31:0] pic_w;

  // All arithmetic is 32-bit unsigned; overflow simply wraps.
  assign pic_w    = 32'(total_x_i) + 32'd1;
  assign mb_off_o = 32'(mb_y_i) * pic_w + 32'(mb_x_i);

  // Luma MB = 16 words, chroma MB = 8 words (U 16-19, V 20-23 rebased to 0).
  assign addr_o = uv_i ? (UV_BASE + (mb_off_i << 3) + 32'(blk_i - 5'd16))
                       : (Y_BASE  + (mb_off_i << 4) + 32'(blk_i));

endmodule
`default_nettype wire

// File: rtl/db_ext_access.sv
`default_nettype none
// ============================================================================
// Module   : db_ext_access
// Purpose  : Moves 4x4 pixel blocks between the deblocking buffers and
//            external memory, one bus transaction outstanding at a time.
// Ports    : load_*  - read command in, per-beat data/valid and done out
//            store_* - write command in, local RAM read port, done out
//            ext_*   - external word bus (req/ack, read data w/ rvalid)
// Revision : 1.0 - initial release
// ============================================================================
module db_ext_access
  import db_ext_access_pkg::*;
#(
  parameter int          BIT_DEPTH    = DEF_BIT_DEPTH,
  parameter int          PIC_W_MB_LEN = DEF_PIC_W_MB_LEN,
  parameter int          PIC_H_MB_LEN = DEF_PIC_H_MB_LEN,
  parameter logic [31:0] Y_BASE       = 32'h0,
  parameter logic [31:0] UV_BASE      = 32'h0010_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIC_W_MB_LEN-1:0] sys_total_x,
  input  logic                    load_en_i,
  input  logic [PIC_W_MB_LEN-1:0] load_x_i,
  input  logic [PIC_H_MB_LEN-1:0] load_y_i,
  input  logic [1:0]              load_mode_i,
  output logic                    load_valid_o,
  output logic [16*BIT_DEPTH-1:0] load_data_o,
  output logic                    load_done_o,
  input  logic                    store_en_i,
  input  logic [PIC_W_MB_LEN-1:0] store_x_i,
  input  logic [PIC_H_MB_LEN-1:0] store_y_i,
  input  logic [1:0]              store_mode_i,
  output logic                    store_rden_o,
  output logic [4:0]              store_raddr_o,
  input  logic [16*BIT_DEPTH-1:0] store_rdata_i,
  output logic                    store_done_o,
  output logic                    ext_req_o,
  output logic                    ext_we_o,
  output logic [31:0]             ext_addr_o,
  output logic [16*BIT_DEPTH-1:0] ext_wdata_o,
  input  logic                    ext_ack_i,
  input  logic                    ext_rvalid_i,
  input  logic [16*BIT_DEPTH-1:0] ext_rdata_i
);

  localparam int DW = 16 * BIT_DEPTH;

  state_e      state_q, state_d;
  logic [4:0]  beat_q, beat_d;
  logic        fetch_ph_q, fetch_ph_d;   // 0: RAM read issued, 1: data arriving
  logic [1:0]  mode_q;
  logic        is_store_q;
  logic [31:0] mb_off_q;
  logic [DW-1:0] wdata_q;

  logic        start_load, start_store, last_beat;
  logic [4:0]  blk;
  logic [31:0] mb_off_new, blk_addr;

  assign start_load  = (state_q == S_IDLE) && load_en_i;
  assign start_store = (state_q == S_IDLE) && !load_en_i && store_en_i;
  assign blk         = blk_index(mode_q, beat_q);
  assign last_beat   = (beat_q == beat_count(mode_q) - 5'd1);

  db_ext_addr_gen #(
    .PIC_W_MB_LEN (PIC_W_MB_LEN),
    .PIC_H_MB_LEN (PIC_H_MB_LEN),
    .Y_BASE       (Y_BASE),
    .UV_BASE      (UV_BASE)
  ) u_addr_gen (
    .total_x_i (sys_total_x),
    .mb_x_i    (load_en_i ? load_x_i : store_x_i),
    .mb_y_i    (load_en_i ? load_y_i : store_y_i),
    .mb_off_o  (mb_off_new),
    .mb_off_i  (mb_off_q),
    .uv_i      (mode_q[1]),
    .blk_i     (blk),
    .addr_o    (blk_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      fetch_ph_q <= 1'b0;
      mode_q     <= '0;
      is_store_q <= 1'b0;
      mb_off_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      fetch_ph_q <= fetch_ph_d;
      // Command is latched once; the MB offset is not recomputed per beat.
      if (start_load || start_store) begin
        mode_q     <= load_en_i ? load_mode_i : store_mode_i;
        is_store_q <= start_store;
        mb_off_q   <= mb_off_new;
      end
      if ((state_q == S_WR_FETCH) && fetch_ph_q) begin
        wdata_q <= store_rdata_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    fetch_ph_d = fetch_ph_q;
    case (state_q)
      S_IDLE: begin
        beat_d     = '0;
        fetch_ph_d = 1'b0;
        if (start_load) begin
          state_d = S_RD_REQ;
        end else if (start_store) begin
          state_d = S_WR_FETCH;
        end
      end
      S_RD_REQ: begin
        if (ext_ack_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (ext_rvalid_i) begin
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_REQ;
            beat_d  = beat_q + 5'd1;
          end
        end
      end
      S_WR_FETCH: begin
        fetch_ph_d = !fetch_ph_q;
        if (fetch_ph_q) state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (ext_ack_i) begin
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR_FETCH;
            beat_d  = beat_q + 5'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ext_req_o     = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign ext_we_o      = (state_q == S_WR_REQ);
  assign ext_addr_o    = ext_req_o ? blk_addr : '0;
  assign ext_wdata_o   = wdata_q;
  assign load_valid_o  = (state_q == S_RD_WAIT) && ext_rvalid_i;
  assign load_data_o   = load_valid_o ? ext_rdata_i : '0;
  assign load_done_o   = (state_q == S_DONE) && !is_store_q;
  assign store_done_o  = (state_q == S_DONE) && is_store_q;
  assign store_rden_o  = (state_q == S_WR_FETCH) && !fetch_ph_q;
  assign store_raddr_o = store_rden_o ? blk : '0;

endmodule
`default_nettype wire

// File: doc/db_ext_access.md
DB_EXT_ACCESS -- requirements
Module: db_ext_access

Interface
REQ-001 Parameters (name, default, meaning): BIT_DEPTH, 8, pixel width; PIC_W_MB_LEN, 8, MB x width; PIC_H_MB_LEN, 8, MB y width; Y_BASE, 32'h0, luma word base; UV_BASE, 32'h0010_0000, chroma word base.
REQ-002 Ports (name direction width meaning): clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 sys_total_x in PIC_W_MB_LEN last MB x index, so picture width is sys_total_x+1 MBs.
REQ-004 Load ports: load_en_i in 1 request level; load_x_i in PIC_W_MB_LEN; load_y_i in PIC_H_MB_LEN; load_mode_i in 2 ([1] Y/UV, [0] bottom line/full); load_valid_o out 1; load_data_o out 16*BIT_DEPTH; load_done_o out 1.
REQ-005 Store ports: store_en_i in 1; store_x_i, store_y_i, store_mode_i (widths and encoding as load); store_rden_o out 1; store_raddr_o out 5; store_rdata_i in 16*BIT_DEPTH; store_done_o out 1.
REQ-006 Bus ports: ext_req_o out 1; ext_we_o out 1; ext_addr_o out 32 (16-byte word address); ext_wdata_o out 16*BIT_DEPTH; ext_ack_i in 1; ext_rvalid_i in 1; ext_rdata_i in 16*BIT_DEPTH.

Function
REQ-007 One beat = one 4x4 block; at most one bus transaction outstanding.
REQ-008 Beat counts: mode 00 = 4 (Y blocks 12-15); 10 = 4 (U 18,19, V 22,23); 01 = 16 (Y 0-15); 11 = 8 (U 16-19, V 20-23); beats issue in ascending block index.
REQ-009 Address = base + (y*(sys_total_x+1)+x)*K + blk; K=16, base Y_BASE for Y; K=8, base UV_BASE, blk-16 for UV; mb offset computed once per command, 32-bit unsigned, wrap-around allowed.
REQ-010 FSM states: IDLE, RD_REQ, RD_WAIT, WR_FETCH, WR_REQ, DONE.
REQ-011 IDLE: load_en_i -> RD_REQ; else store_en_i -> WR_FETCH; both high -> load wins; command inputs latched on exit.
REQ-012 RD_REQ: ext_req_o=1, ext_we_o=0 until ext_ack_i, then RD_WAIT.
REQ-013 RD_WAIT: on ext_rvalid_i drive load_valid_o=1 and load_data_o=ext_rdata_i same cycle (combinational pass or 0-cycle register equivalent); next RD_REQ, or DONE after last beat.
REQ-014 WR_FETCH: store_rden_o=1 one cycle with store_raddr_o=block index; store_rdata_i captured next cycle (1-cycle RAM latency) into ext_wdata_o; then WR_REQ.
REQ-015 WR_REQ: ext_req_o=1, ext_we_o=1, ext_wdata_o stable until ext_ack_i; next WR_FETCH, or DONE after last beat.
REQ-016 DONE: one-cycle pulse on load_done_o or store_done_o per command type, then IDLE; done never coincides with load_valid_o.
REQ-017 ext_addr_o, ext_we_o, ext_wdata_o held stable while ext_req_o=1 and ext_ack_i=0.
REQ-018 ext_rvalid_i outside RD_WAIT and ext_ack_i outside request states are ignored.
REQ-019 Requests deasserted before done are not aborted; command completes.

Reset
REQ-020 Async reset: state IDLE, beat counter 0; all outputs 0, including data/address buses.
REQ-021 Reset mid-transaction abandons it; no done pulse afterwards.

Structure
REQ-022 Beat counts, block start indices, and state encodings reside in shared enc_defines include; BIT_DEPTH and PIC_*_LEN from same.
REQ-023 One sub-module natural: db_ext_addr_gen (MB offset multiply, block-to-address map).

Verification
REQ-024 total_x=9, load (x3,y2,mode00), ack and rvalid 1 cycle later -> addresses 0x17C-0x17F, 4 load_valid, load_done 1 cycle after 4th valid.
REQ-025 Store (x0,y0,mode11), ack delayed 3 cycles -> raddr 16..23, addr UV_BASE+0..7, wdata = RAM data, held during stall, one store_done.
REQ-026 load_en_i and store_en_i rise together -> load completes first, then store.
REQ-027 Back-to-back: mode00 done then en held with mode10 -> second command starts from IDLE, no lost or duplicate beats.
REQ-028 rst_n low during RD_WAIT of beat 2 -> outputs 0, IDLE, no done; new command after release completes normally.
REQ-029 Spurious ext_rvalid_i in IDLE -> no load_valid_o.
